// File: rtl/rng_pkg.sv
// Shared types and helpers for the range-limited random sampler.
package rng_pkg;

   localparam int OUT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      RUN   = 2'd2
   } rng_state_e;

   // Smallest 2^k-1 that covers rng-1; a range of 0 or 1 maps to mask 0.
   function automatic logic [31:0] mask_for(input logic [31:0] rng);
      logic [31:0] m;
      m = (rng == 32'd0) ? 32'd0 : rng - 32'd1;
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      m = m | (m >> 16);
      return m;
   endfunction

endpackage

// File: rtl/rng_fifo.sv
// First-word-fall-through FIFO with a registered head and a synchronous flush.
module rng_fifo #(
   parameter  int W     = 16,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          CLK,
   input  logic          RESETL,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  wr_data,
   output logic [W-1:0]  rd_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] fill
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_ptr_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic [W-1:0]  head_q;
   logic [W-1:0]  head_n;
   logic          do_push;
   logic          do_pop;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      do_pop   = pop && (cnt != '0);
      do_push  = push && ((cnt != CW'(DEPTH)) || do_pop);
      rd_ptr_n = do_pop ? rd_ptr + AW'(1) : rd_ptr;
      cnt_n    = cnt;
      if (do_push && !do_pop)      cnt_n = cnt + CW'(1);
      else if (!do_push && do_pop) cnt_n = cnt - CW'(1);
      head_n   = (do_push && (wr_ptr == rd_ptr_n)) ? wr_data : mem[rd_ptr_n];
   end

   always_ff @(posedge CLK) begin
      if (do_push && !flush) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge CLK or negedge RESETL) begin
      if (!RESETL) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         head_q <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_ptr_n;
         cnt    <= cnt_n;
         // Head keeps its last value while the FIFO is empty.
         if (cnt_n != '0) head_q <= head_n;
      end
   end

   assign rd_data = head_q;
   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign fill    = cnt;

endmodule

// File: rtl/rng_range.sv
// Mask-and-reject sampler turning raw LFSR words into uniform values in [0, range).
module rng_range
   import rng_pkg::*;
#(
   parameter  int OUT_W = OUT_W_DEF,
   parameter  int DEPTH = 4,
   localparam int FW    = $clog2(DEPTH) + 1
) (
   input  logic             CLK,
   input  logic             RESETL,
   input  logic [31:0]      RAW_DATA,
   input  logic [OUT_W-1:0] RANGE_IN,
   input  logic             RANGE_LOAD,
   output logic [OUT_W-1:0] OUT_DATA,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [FW-1:0]    FILL,
   output logic [15:0]      REJECT_CNT,
   output rng_state_e       DBG_STATE
);

   rng_state_e       state_q;
   rng_state_e       state_d;
   logic [OUT_W-1:0] range_r;
   logic [OUT_W-1:0] mask_r;
   logic [31:0]      mask_full;
   logic [OUT_W-1:0] cand;
   logic             sample_en;
   logic             push;
   logic             reject;
   logic             fifo_full;
   logic             fifo_empty;
   logic             unused_ok;

   // A load pulse overrides every other transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SETUP:   state_d = RUN;
         default: state_d = state_q;
      endcase
      if (RANGE_LOAD) state_d = (RANGE_IN != '0) ? SETUP : IDLE;
   end

   always_ff @(posedge CLK or negedge RESETL) begin
      if (!RESETL) state_q <= IDLE;
      else         state_q <= state_d;
   end

   assign mask_full = mask_for(32'(range_r));
   assign cand      = RAW_DATA[OUT_W-1:0] & mask_r;
   assign sample_en = (state_q == RUN) && !RANGE_LOAD;
   assign push      = sample_en && (cand < range_r);
   assign reject    = sample_en && (cand >= range_r);

   always_ff @(posedge CLK or negedge RESETL) begin
      if (!RESETL) begin
         range_r    <= '0;
         mask_r     <= '0;
         REJECT_CNT <= '0;
      end else if (RANGE_LOAD) begin
         range_r    <= RANGE_IN;
         REJECT_CNT <= '0;
      end else begin
         if (state_q == SETUP) mask_r <= mask_full[OUT_W-1:0];
         if (reject && (REJECT_CNT != 16'hFFFF)) REJECT_CNT <= REJECT_CNT + 16'd1;
      end
   end

   // Handshake: OUT_DATA is consumed at a rising edge where OUT_VALID && OUT_READY;
   // OUT_VALID comes from the registered occupancy, never from OUT_READY.
   rng_fifo #(
      .W     (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RESETL  (RESETL),
      .push    (push),
      .pop     (OUT_READY),
      .flush   (RANGE_LOAD),
      .wr_data (cand),
      .rd_data (OUT_DATA),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .fill    (FILL)
   );

   assign OUT_VALID = !fifo_empty;
   assign DBG_STATE = state_q;
   assign unused_ok = ^{RAW_DATA, mask_full, fifo_full};

endmodule

// File: tb/tb_rng_range.sv
// Directed bench for rng_range: scoreboard of accepted samples plus register checks.
module tb_rng_range;
   import rng_pkg::*;

   localparam int OUT_W = 16;
   localparam int DEPTH = 4;

   logic             CLK;
   logic             RESETL;
   logic [31:0]      RAW_DATA;
   logic [OUT_W-1:0] RANGE_IN;
   logic             RANGE_LOAD;
   logic [OUT_W-1:0] OUT_DATA;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [2:0]       FILL;
   logic [15:0]      REJECT_CNT;
   rng_state_e       DBG_STATE;

   int tests = 0;
   int fails = 0;
   int flushed = 0;
   logic [OUT_W-1:0] exp_q[$];

   rng_range #(.OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
      .CLK        (CLK),
      .RESETL     (RESETL),
      .RAW_DATA   (RAW_DATA),
      .RANGE_IN   (RANGE_IN),
      .RANGE_LOAD (RANGE_LOAD),
      .OUT_DATA   (OUT_DATA),
      .OUT_VALID  (OUT_VALID),
      .OUT_READY  (OUT_READY),
      .FILL       (FILL),
      .REJECT_CNT (REJECT_CNT),
      .DBG_STATE  (DBG_STATE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Random word with a chosen low nibble (ranges 10/16 mask to the nibble).
   function automatic logic [31:0] rh(input logic [3:0] nib);
      logic [31:0] r;
      r = $urandom();
      return {r[31:4], nib};
   endfunction

   task automatic sample(input logic [31:0] raw, input bit acc, input logic [31:0] v);
      RAW_DATA = raw;
      if (acc) exp_q.push_back(v[OUT_W-1:0]);
      tick();
   endtask

   task automatic load(input logic [31:0] n);
      RANGE_IN   = n[OUT_W-1:0];
      RANGE_LOAD = 1'b1;
      tick();
      RANGE_LOAD = 1'b0;
      flushed = exp_q.size();
      exp_q.delete();
      check("load_fill", 32'(FILL), 0);
      check("load_rej", 32'(REJECT_CNT), 0);
      check("load_valid", 32'(OUT_VALID), 0);
      check("load_state", 32'(DBG_STATE), (n != 0) ? 32'(SETUP) : 32'(IDLE));
   endtask

   // Consumer side: every handshake pops the oldest expected sample.
   always @(negedge CLK) begin
      if (RESETL && OUT_VALID && OUT_READY) begin
         if (exp_q.size() == 0) check("pop_unexpected", 32'(OUT_DATA), 32'hFFFF_FFFF);
         else                   check("pop_data", 32'(OUT_DATA), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      RESETL = 1'b0; RAW_DATA = '0; RANGE_IN = '0; RANGE_LOAD = 1'b0; OUT_READY = 1'b0;
      repeat (3) tick();
      check("rst_state", 32'(DBG_STATE), 32'(IDLE));
      check("rst_fill", 32'(FILL), 0);
      check("rst_valid", 32'(OUT_VALID), 0);
      check("rst_data", 32'(OUT_DATA), 0);
      check("rst_rej", 32'(REJECT_CNT), 0);
      RESETL = 1'b1;
      RAW_DATA = $urandom();
      tick();
      check("post_rst_valid", 32'(OUT_VALID), 0);

      // Rejection: range 10, mask 0xF
      load(10);
      tick();
      check("run_state", 32'(DBG_STATE), 32'(RUN));
      check("pre_valid", 32'(OUT_VALID), 0);
      OUT_READY = 1'b1;
      sample(rh(3), 1, 3);
      check("first_valid", 32'(OUT_VALID), 1);
      sample(rh(12), 0, 0);
      sample(rh(9), 1, 9);
      sample(rh(15), 0, 0);
      sample(rh(0), 1, 0);
      check("rej_cnt", 32'(REJECT_CNT), 2);
      load(0);
      check("rej_drained", 32'(flushed), 0);

      // Backpressure: range 16 accepts every nibble
      OUT_READY = 1'b0;
      load(16);
      tick();
      for (int v = 1; v <= 6; v++) sample(rh(4'(v)), (v <= 4), 32'(v));
      check("bp_fill", 32'(FILL), 4);
      check("bp_head", 32'(OUT_DATA), 1);
      check("bp_rej", 32'(REJECT_CNT), 0);
      OUT_READY = 1'b1;
      sample(rh(7), 1, 7);
      check("pushpop_fill", 32'(FILL), 4);
      for (int v = 8; v <= 11; v++) sample(rh(4'(v)), 1, 32'(v));
      check("pushpop_fill2", 32'(FILL), 4);
      load(0);
      check("bp_leftover", 32'(flushed), 3);

      // Reload flush to range 1
      OUT_READY = 1'b0;
      load(10);
      tick();
      sample(rh(1), 1, 1);
      sample(rh(12), 0, 0);
      sample(rh(2), 1, 2);
      sample(rh(3), 1, 3);
      check("pre_flush_fill", 32'(FILL), 3);
      check("pre_flush_rej", 32'(REJECT_CNT), 1);
      load(1);
      check("flush_discard", 32'(flushed), 3);
      tick();
      OUT_READY = 1'b1;
      repeat (6) sample($urandom(), 1, 0);
      check("range1_rej", 32'(REJECT_CNT), 0);

      // Largest range: mask is all ones, only 0xFFFF is rejected
      load(32'hFFFF);
      tick();
      sample({16'($urandom()), 16'hFFFE}, 1, 32'hFFFE);
      sample({16'($urandom()), 16'hFFFF}, 0, 0);
      sample({16'($urandom()), 16'h1234}, 1, 32'h1234);
      check("max_rej", 32'(REJECT_CNT), 1);

      // Reject counter saturation
      load(10);
      tick();
      RAW_DATA = rh(15);
      repeat (65540) tick();
      check("rej_sat", 32'(REJECT_CNT), 32'hFFFF);
      check("rej_sat_valid", 32'(OUT_VALID), 0);

      // Asynchronous reset in the middle of RUN
      OUT_READY = 1'b0;
      load(16);
      tick();
      sample(rh(5), 1, 5);
      sample(rh(6), 1, 6);
      check("mid_fill", 32'(FILL), 2);
      check("mid_data", 32'(OUT_DATA), 5);
      #3;
      RESETL = 1'b0;
      #1;
      exp_q.delete();
      check("arst_fill", 32'(FILL), 0);
      check("arst_valid", 32'(OUT_VALID), 0);
      check("arst_data", 32'(OUT_DATA), 0);
      check("arst_rej", 32'(REJECT_CNT), 0);
      check("arst_state", 32'(DBG_STATE), 32'(IDLE));
      tick();
      tick();
      RESETL = 1'b1;
      for (int i = 0; i < 5; i++) begin
         RAW_DATA = $urandom();
         tick();
         check("arst_idle_valid", 32'(OUT_VALID), 0);
      end
      load(16);
      tick();
      check("reload_t2_valid", 32'(OUT_VALID), 0);
      sample(rh(9), 1, 9);
      check("reload_t3_valid", 32'(OUT_VALID), 1);
      check("reload_t3_data", 32'(OUT_DATA), 9);

      // Idle after a zero-range load
      load(0);
      OUT_READY = 1'b1;
      for (int i = 0; i < 100; i++) begin
         RAW_DATA = $urandom();
         tick();
         check("idle_valid", 32'(OUT_VALID), 0);
         check("idle_rej", 32'(REJECT_CNT), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
